// File: rtl/ascon_serial_host.sv
// ascon_serial_host -- initiator side of the bit-serial Ascon pin interface.
//
// Takes one parallel job (key, nonce, AD, data, direction, expected tag) on a
// valid/ready command port, shifts the four operands out MSB first one bit
// per cycle, pulses start, waits for the core's ready, then deserialises the
// returned data and tag into a parallel response held until rsp_ready.
//
// Optional feature macro: ASCON_HOST_TIMEOUT_EN -- WAIT watchdog of
// TIMEOUT_CYCLES cycles. When it fires, DONE is entered with rsp_timeout=1
// and zeroed data/tag. Without the macro, WAIT blocks indefinitely and
// rsp_timeout is tied low.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   cmd_valid/cmd_ready         job handshake (ready only in IDLE)
//   cmd_key/nonce/ad/data       W-bit operands, captured at accept
//   cmd_decrypt, cmd_exp_tag    direction, expected tag for decrypt
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_tag           deserialised results
//   rsp_tag_ok, rsp_timeout     tag check result, watchdog flag
//   keyxSO..input_dataxSO       serial operand streams to the core
//   ascon_startxSO, decryptxSO  start pulse, held direction
//   output_dataxSI, tagxSI,     serial results and ready from the core
//   ascon_readyxSI

// One serial lane: parallel load, or shift left with a serial bit at the LSB.
module ascon_host_shreg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         sh,
  input  logic         sin,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (ld) q <= ld_val;
    else if (sh) q <= {q[W-2:0], sin};
  end
endmodule

module ascon_serial_host #(
  parameter int W              = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_key,
  input  logic [W-1:0] cmd_nonce,
  input  logic [W-1:0] cmd_ad,
  input  logic [W-1:0] cmd_data,
  input  logic         cmd_decrypt,
  input  logic [W-1:0] cmd_exp_tag,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rsp_tag,
  output logic         rsp_tag_ok,
  output logic         rsp_timeout,
  output logic         keyxSO,
  output logic         noncexSO,
  output logic         associated_dataxSO,
  output logic         input_dataxSO,
  output logic         ascon_startxSO,
  output logic         decryptxSO,
  input  logic         output_dataxSI,
  input  logic         tagxSI,
  input  logic         ascon_readyxSI
);
  localparam int NS = 4;                 // operand streams
  localparam int NR = 2;                 // result streams
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_LOAD = CW'(W - 1);
  localparam logic [CW-1:0] LAST_CAP  = CW'(W - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            dec_q;
  logic [W-1:0]    exp_tag_q;
  logic            tag_ok_q;
  logic            accept, in_load, cap_en, cap_last, tmo_fire;
  logic [W-1:0]    tag_nx;

  logic [NS-1:0][W-1:0] op_par, op_q;
  logic [NR-1:0][W-1:0] res_q;
  logic [NR-1:0]        res_sin;

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign in_load  = (state == S_LOAD);
  // First result bit is taken on the WAIT edge that sees ready.
  assign cap_en   = ((state == S_WAIT) && ascon_readyxSI) || (state == S_CAPTURE);
  assign cap_last = (state == S_CAPTURE) && (cnt == LAST_CAP);
  assign tag_nx   = {res_q[1][W-2:0], tagxSI};

  assign op_par  = {cmd_data, cmd_ad, cmd_nonce, cmd_key};
  assign res_sin = {tagxSI, output_dataxSI};

  // Operand lanes: loaded at accept, shifted out during LOAD.
  for (genvar i = 0; i < NS; i++) begin : g_op
    ascon_host_shreg #(.W(W)) u_lane (
      .clk(clk), .rst(rst), .ld(accept), .ld_val(op_par[i]),
      .sh(in_load), .sin(1'b0), .q(op_q[i])
    );
  end

  // Result lanes double as the response registers; a watchdog clears them.
  for (genvar i = 0; i < NR; i++) begin : g_res
    ascon_host_shreg #(.W(W)) u_lane (
      .clk(clk), .rst(rst), .ld(tmo_fire), .ld_val('0),
      .sh(cap_en), .sin(res_sin[i]), .q(res_q[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (cmd_valid)          state_nx = S_LOAD;
      S_LOAD:    if (cnt == LAST_LOAD)   state_nx = S_START;
      S_START:                           state_nx = S_WAIT;
      S_WAIT:    if (ascon_readyxSI)     state_nx = S_CAPTURE;
                 else if (tmo_fire)      state_nx = S_DONE;
      S_CAPTURE: if (cnt == LAST_CAP)    state_nx = S_DONE;
      S_DONE:    if (rsp_ready)          state_nx = S_IDLE;
      default:                           state_nx = S_IDLE;
    endcase
  end

  // Bit counter, reused for LOAD and CAPTURE; transitions are exact so it
  // never needs to saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else begin
      unique case (state)
        S_LOAD:    cnt <= (cnt == LAST_LOAD) ? '0 : cnt + CW'(1);
        S_CAPTURE: cnt <= cnt + CW'(1);
        default:   cnt <= '0;
      endcase
    end
  end

  // Job context and tag verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q     <= 1'b0;
      exp_tag_q <= '0;
      tag_ok_q  <= 1'b0;
    end else begin
      if (accept) begin
        dec_q     <= cmd_decrypt;
        exp_tag_q <= cmd_exp_tag;
      end
      if (cap_last)      tag_ok_q <= !dec_q || (tag_nx == exp_tag_q);
      else if (tmo_fire) tag_ok_q <= 1'b0;
    end
  end

`ifdef ASCON_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  // Counts WAIT cycles without ready; fires on the last allowed one.
  assign tmo_fire = (state == S_WAIT) && !ascon_readyxSI &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !ascon_readyxSI) tmo_cnt <= tmo_cnt + TW'(1);
      else                                      tmo_cnt <= '0;
      if (accept)        tmo_q <= 1'b0;
      else if (tmo_fire) tmo_q <= 1'b1;
    end
  end
  assign rsp_timeout = tmo_q;
`else
  assign tmo_fire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Outputs
  assign cmd_ready          = (state == S_IDLE);
  assign rsp_valid          = (state == S_DONE);
  assign rsp_data           = res_q[0];
  assign rsp_tag            = res_q[1];
  assign rsp_tag_ok         = tag_ok_q;
  assign keyxSO             = in_load & op_q[0][W-1];
  assign noncexSO           = in_load & op_q[1][W-1];
  assign associated_dataxSO = in_load & op_q[2][W-1];
  assign input_dataxSO      = in_load & op_q[3][W-1];
  assign ascon_startxSO     = (state == S_START);
  assign decryptxSO         = (state != S_IDLE) & dec_q;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host: a W=8 instance for stream, tag,
// ignored-input and watchdog cases, a W=128 instance for the full-width
// round trip and reset mid-capture. Both share the serial result pins; a
// select steers the command port and the observed outputs.
module tb_ascon_serial_host;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel;  // 1 = W=8 instance, 0 = W=128 instance
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_decrypt, rsp_ready, rdy_si, dat_si, tag_si;
  logic [127:0] cmd_key, cmd_nonce, cmd_ad, cmd_data, cmd_exp_tag;

  logic s_cmd_ready, s_rsp_valid, s_ok, s_tmo, s_k, s_n, s_a, s_d, s_st, s_dec;
  logic b_cmd_ready, b_rsp_valid, b_ok, b_tmo, b_k, b_n, b_a, b_d, b_st, b_dec;
  logic [7:0]   s_rsp_data, s_rsp_tag;
  logic [127:0] b_rsp_data, b_rsp_tag;

  ascon_serial_host #(.W(8), .TIMEOUT_CYCLES(TMO)) u_small (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(s_cmd_ready),
    .cmd_key(cmd_key[7:0]), .cmd_nonce(cmd_nonce[7:0]), .cmd_ad(cmd_ad[7:0]),
    .cmd_data(cmd_data[7:0]), .cmd_decrypt(cmd_decrypt), .cmd_exp_tag(cmd_exp_tag[7:0]),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
    .rsp_tag(s_rsp_tag), .rsp_tag_ok(s_ok), .rsp_timeout(s_tmo),
    .keyxSO(s_k), .noncexSO(s_n), .associated_dataxSO(s_a), .input_dataxSO(s_d),
    .ascon_startxSO(s_st), .decryptxSO(s_dec),
    .output_dataxSI(dat_si), .tagxSI(tag_si), .ascon_readyxSI(rdy_si)
  );

  ascon_serial_host #(.W(128), .TIMEOUT_CYCLES(TMO)) u_big (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(b_cmd_ready),
    .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_ad(cmd_ad),
    .cmd_data(cmd_data), .cmd_decrypt(cmd_decrypt), .cmd_exp_tag(cmd_exp_tag),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
    .rsp_tag(b_rsp_tag), .rsp_tag_ok(b_ok), .rsp_timeout(b_tmo),
    .keyxSO(b_k), .noncexSO(b_n), .associated_dataxSO(b_a), .input_dataxSO(b_d),
    .ascon_startxSO(b_st), .decryptxSO(b_dec),
    .output_dataxSI(dat_si), .tagxSI(tag_si), .ascon_readyxSI(rdy_si)
  );

  // Observed outputs of the selected instance
  logic         cmd_ready_m, rsp_valid_m, ok_m, tmo_m, key_so, non_so, ad_so, dat_so, st_so, dec_so;
  logic [127:0] rsp_data_m, rsp_tag_m;
  assign cmd_ready_m = sel ? s_cmd_ready : b_cmd_ready;
  assign rsp_valid_m = sel ? s_rsp_valid : b_rsp_valid;
  assign ok_m        = sel ? s_ok  : b_ok;
  assign tmo_m       = sel ? s_tmo : b_tmo;
  assign key_so      = sel ? s_k   : b_k;
  assign non_so      = sel ? s_n   : b_n;
  assign ad_so       = sel ? s_a   : b_a;
  assign dat_so      = sel ? s_d   : b_d;
  assign st_so       = sel ? s_st  : b_st;
  assign dec_so      = sel ? s_dec : b_dec;
  assign rsp_data_m  = sel ? 128'(s_rsp_data) : b_rsp_data;
  assign rsp_tag_m   = sel ? 128'(s_rsp_tag)  : b_rsp_tag;

  typedef struct {
    logic [127:0] key, nonce, ad, data, exp_tag, ret_data, ret_tag;
    logic         dec;
    int           rdy_dly;   // WAIT cycle (0-based) ready appears; <0 = never
    logic         exp_ok;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 128'(act), 128'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job on the selected instance, acting as the core model.
  task automatic run_job(input int w, input vec_t v, input int stall,
                         input bit hold_valid, input int rst_at, input string nm);
    logic [127:0] ks, ns, as_, ds, m, d0, t0;
    logic         ok0;
    bit           b_start, b_early, b_dir, b_rdy, b_hold, bad;
    int           r, c;
    m  = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
    ks = '0; ns = '0; as_ = '0; ds = '0;
    b_start = 0; b_early = 0; b_dir = 0; b_rdy = 0; b_hold = 0;
    c = 0;
    while (cmd_ready_m !== 1'b1 && c < 50) begin step(); c++; end
    chkb({nm, " idle"}, cmd_ready_m, 1'b1);
    cmd_key = v.key; cmd_nonce = v.nonce; cmd_ad = v.ad; cmd_data = v.data;
    cmd_decrypt = v.dec; cmd_exp_tag = v.exp_tag;
    cmd_valid = 1'b1; rsp_ready = 1'b0; rdy_si = 1'b0;
    step();                                   // accept edge crossed: cycle 1
    if (!hold_valid) cmd_valid = 1'b0;
    // LOAD: capture streams; ready toggles and must be ignored.
    for (int n = 1; n <= w; n++) begin
      ks = {ks[126:0], key_so}; ns = {ns[126:0], non_so};
      as_ = {as_[126:0], ad_so}; ds = {ds[126:0], dat_so};
      if (st_so !== 1'b0) b_start = 1;
      if (dec_so !== v.dec) b_dir = 1;
      if (cmd_ready_m !== 1'b0) b_rdy = 1;
      rdy_si = n[0]; dat_si = 1'($urandom); tag_si = 1'($urandom);
      step();
    end
    chk({nm, " key stream"},   ks & m,  v.key & m);
    chk({nm, " nonce stream"}, ns & m,  v.nonce & m);
    chk({nm, " ad stream"},    as_ & m, v.ad & m);
    chk({nm, " data stream"},  ds & m,  v.data & m);
    // START cycle W+1
    chk({nm, " start cycle"}, 128'({st_so, key_so, non_so, ad_so, dat_so}), 128'(5'b10000));
    rdy_si = 1'b1;
    step();
    if (v.rdy_dly < 0) begin
      rdy_si = 1'b0;
      for (c = w + 2; c < w + 2 + TMO; c++) begin
        if (rsp_valid_m !== 1'b0) b_early = 1;
        step();
      end
      chkb({nm, " no early rsp"}, b_early, 1'b0);
`ifdef ASCON_HOST_TIMEOUT_EN
      chkb({nm, " tmo valid"}, rsp_valid_m, 1'b1);
      chkb({nm, " tmo flag"}, tmo_m, 1'b1);
      chkb({nm, " tmo tag_ok"}, ok_m, 1'b0);
      chk({nm, " tmo data"}, rsp_data_m, '0);
      chk({nm, " tmo tag"}, rsp_tag_m, '0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chkb({nm, " tmo back idle"}, cmd_ready_m, 1'b1);
`else
      bad = 0;
      repeat (40) begin
        if (rsp_valid_m !== 1'b0 || tmo_m !== 1'b0) bad = 1;
        step();
      end
      chkb({nm, " wait blocks"}, bad, 1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
`endif
      return;
    end
    // WAIT / CAPTURE
    r = w + 2 + v.rdy_dly;
    for (c = w + 2; c < r + w; c++) begin
      if (rsp_valid_m !== 1'b0 || st_so !== 1'b0 ||
          {key_so, non_so, ad_so, dat_so} !== 4'b0) b_early = 1;
      if (dec_so !== v.dec) b_dir = 1;
      if (cmd_ready_m !== 1'b0) b_rdy = 1;
      if (c < r) begin
        rdy_si = 1'b0; dat_si = 1'($urandom); tag_si = 1'($urandom);
      end else begin
        rdy_si = (c == r) ? 1'b1 : 1'($urandom);
        dat_si = v.ret_data[w-1-(c-r)];
        tag_si = v.ret_tag[w-1-(c-r)];
      end
      if (rst_at >= 0 && c == r + rst_at) begin
        rst = 1'b0;
        #1;
        chk({nm, " async reset outs"},
            128'({cmd_ready_m, rsp_valid_m, ok_m, tmo_m, key_so, non_so, ad_so, dat_so, st_so, dec_so}),
            128'(10'b1000000000));
        chk({nm, " reset data"}, rsp_data_m, '0);
        chk({nm, " reset tag"}, rsp_tag_m, '0);
        rdy_si = 1'b0; cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        repeat (2 * w) begin
          if (rsp_valid_m !== 1'b0) bad = 1;
          step();
        end
        chkb({nm, " no partial rsp"}, bad, 1'b0);
        return;
      end
      step();
    end
    // Cycle R+W: response must be up.
    rdy_si = 1'b0;
    chkb({nm, " pre-rsp quiet"}, b_early, 1'b0);
    chkb({nm, " start only once"}, b_start, 1'b0);
    chkb({nm, " rsp_valid timing"}, rsp_valid_m, 1'b1);
    chk({nm, " rsp_data"}, rsp_data_m & m, v.ret_data & m);
    chk({nm, " rsp_tag"}, rsp_tag_m & m, v.ret_tag & m);
    chkb({nm, " rsp_tag_ok"}, ok_m, v.exp_ok);
    chkb({nm, " rsp_timeout"}, tmo_m, 1'b0);
    chkb({nm, " direction held"}, b_dir, 1'b0);
    chkb({nm, " busy not ready"}, b_rdy, 1'b0);
    d0 = rsp_data_m; t0 = rsp_tag_m; ok0 = ok_m;
    for (int s = 0; s < stall; s++) begin
      rdy_si = 1'($urandom); dat_si = 1'($urandom); tag_si = 1'($urandom);
      step();
      if (rsp_valid_m !== 1'b1 || rsp_data_m !== d0 || rsp_tag_m !== t0 ||
          ok_m !== ok0 || cmd_ready_m !== 1'b0) b_hold = 1;
    end
    if (stall > 0) chkb({nm, " stall stable"}, b_hold, 1'b0);
    rdy_si = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;   // a held request is dropped before it can be taken
    chk({nm, " after handshake"}, 128'({cmd_ready_m, rsp_valid_m, dec_so}), 128'(3'b100));
    chk({nm, " data held in idle"}, rsp_data_m, d0);
  endtask

  vec_t tbl[5];
  vec_t tv, big;

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    cmd_valid = 0; cmd_decrypt = 0; rsp_ready = 0; rdy_si = 0; dat_si = 0; tag_si = 0;
    cmd_key = '0; cmd_nonce = '0; cmd_ad = '0; cmd_data = '0; cmd_exp_tag = '0;
    sel = 1'b1;

    //            key   nonce  ad     data   exp_tag ret_data ret_tag dec dly ok
    tbl[0] = '{128'hA5, 128'h3C, 128'h00, 128'hFF, 128'h00, 128'h5A, 128'hC3, 1'b0, 0, 1'b1};
    tbl[1] = '{128'h11, 128'h22, 128'h33, 128'h44, 128'h81, 128'h96, 128'h80, 1'b1, 2, 1'b0};
    tbl[2] = '{128'h11, 128'h22, 128'h33, 128'h44, 128'h80, 128'h96, 128'h80, 1'b1, 5, 1'b1};
    tbl[3] = '{128'h80, 128'h01, 128'hF0, 128'h0F, 128'h00, 128'hE7, 128'h7E, 1'b0, 3, 1'b1};
    tbl[4] = '{128'h5A, 128'hC3, 128'h96, 128'h69, 128'hFE, 128'h01, 128'hFE, 1'b1, 1, 1'b1};

    // Reset values, both instances
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs small",
        128'({cmd_ready_m, rsp_valid_m, ok_m, tmo_m, key_so, non_so, ad_so, dat_so, st_so, dec_so}),
        128'(10'b1000000000));
    chk("reset rsp small", {rsp_data_m[63:0], rsp_tag_m[63:0]}, '0);
    sel = 1'b0;
    #1;
    chk("reset outs big",
        128'({cmd_ready_m, rsp_valid_m, ok_m, tmo_m, key_so, non_so, ad_so, dat_so, st_so, dec_so}),
        128'(10'b1000000000));
    chk("reset rsp big", rsp_data_m | rsp_tag_m, '0);
    rst = 1'b1;
    sel = 1'b1;

    for (int i = 0; i < 5; i++)
      run_job(8, tbl[i], (i == 2) ? 5 : 0, 1'b0, -1, $sformatf("vec%0d", i));

    // Request held high through a job, response stalled 5 cycles
    run_job(8, tbl[3], 5, 1'b1, -1, "hold");

    // Ready never comes
    tv = tbl[0];
    tv.rdy_dly = -1;
    run_job(8, tv, 0, 1'b0, -1, "watchdog");
    run_job(8, tbl[4], 0, 1'b0, -1, "post-watchdog");

    // Full-width round trip
    sel = 1'b0;
    big = '{128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
            128'h0, 128'h202122232425262728292a2b2c2d2e2f, 128'h0,
            128'h8e2f_1b04_d3c7_5a69_f0e1_d2c3_b4a5_9687,
            128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0, 3, 1'b1};
    run_job(128, big, 0, 1'b0, -1, "enc128");

    // Reset after 40 captured bits, then a clean decrypt job
    tv = big;
    tv.rdy_dly = 0;
    run_job(128, tv, 0, 1'b0, 40, "rst-capture");
    tv = big;
    tv.dec = 1'b1; tv.exp_tag = big.ret_tag; tv.rdy_dly = 1;
    run_job(128, tv, 2, 1'b0, -1, "after-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
